// File: rtl/ex_mul_unit.sv
// Iterative shift-add multiplier for the EX stage: retires BITS_PER_CYCLE multiplier
// bits per cycle and stalls the pipeline until the low WIDTH bits of the product are ready.
module ex_mul_unit #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    output logic             stall_o,
    output logic             busy_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);
    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_busy;

    logic [WIDTH-1:0] w_partial;
    logic [WIDTH-1:0] w_acc_next;
    logic             w_go;

    // Partial product of mcand and the low multiplier bits, as a small shift-add tree.
    always_comb begin
        w_partial = '0;
        for (int b = 0; b < BITS_PER_CYCLE; b++) begin
            if (r_mplier[b]) w_partial = w_partial + (r_mcand << b);
        end
    end

    assign w_acc_next = r_acc + w_partial;
    assign w_go       = (r_state == S_IDLE) && start_i && !flush_i;
    assign stall_o    = w_go || (r_state == S_BUSY);
    assign busy_o     = r_busy;
    assign valid_o    = r_valid;
    assign data_o     = r_data;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state  <= S_IDLE;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_go) begin
                        r_mcand  <= data1_i;
                        r_mplier <= data2_i;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (flush_i) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_acc    <= w_acc_next;
                        r_mcand  <= r_mcand << BITS_PER_CYCLE;
                        r_mplier <= r_mplier >> BITS_PER_CYCLE;
                        r_cnt    <= r_cnt + CW'(1);
                        if (r_cnt == LAST) begin
                            r_data  <= w_acc_next;
                            r_valid <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_DONE;
                        end
                    end
                end
                // DONE (and any stray encoding) always drains back to IDLE; start_i is ignored.
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ex_mul_unit.sv
// Bench for ex_mul_unit: directed table, flush/reset/back-to-back sequences and a
// random sweep across BITS_PER_CYCLE = 2, 1, 4 against a plain-arithmetic product model.
module tb_ex_mul_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, flush;
    logic [31:0] data1, data2;

    logic        m_stall, m_busy, m_valid;
    logic [31:0] m_data;
    logic        s1_stall, s1_busy, s1_valid;
    logic [31:0] s1_data;
    logic        s4_stall, s4_busy, s4_valid;
    logic [31:0] s4_data;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_main = 32'h0;

    always #5 clk = ~clk;

    ex_mul_unit #(.WIDTH(32), .BITS_PER_CYCLE(2)) u_m (
        .clk_i(clk), .rst_i(rst_n), .start_i(start), .flush_i(flush),
        .data1_i(data1), .data2_i(data2),
        .stall_o(m_stall), .busy_o(m_busy), .valid_o(m_valid), .data_o(m_data));
    ex_mul_unit #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_1 (
        .clk_i(clk), .rst_i(rst_n), .start_i(start), .flush_i(flush),
        .data1_i(data1), .data2_i(data2),
        .stall_o(s1_stall), .busy_o(s1_busy), .valid_o(s1_valid), .data_o(s1_data));
    ex_mul_unit #(.WIDTH(32), .BITS_PER_CYCLE(4)) u_4 (
        .clk_i(clk), .rst_i(rst_n), .start_i(start), .flush_i(flush),
        .data1_i(data1), .data2_i(data2),
        .stall_o(s4_stall), .busy_o(s4_busy), .valid_o(s4_valid), .data_o(s4_data));

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        return p[31:0];
    endfunction

    // One MUL starting in the current cycle (cycle 0). hold keeps start_i up until stall_o falls.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit hold, input bit sweep);
        logic [31:0] exp;
        int vm = 0, v1 = 0, v4 = 0;
        int cm = -1, c1 = -1, c4 = -1;
        logic [31:0] dm = '0, d1 = '0, d4 = '0;
        bit stall_ok = 1'b1;
        bit s;
        exp = model(a, b);
        data1 = a; data2 = b; start = 1'b1;
        for (int c = 0; c < 36; c++) begin
            @(negedge clk);
            if (m_valid)  begin vm++; cm = c; dm = m_data;  end
            if (s1_valid) begin v1++; c1 = c; d1 = s1_data; end
            if (s4_valid) begin v4++; c4 = c; d4 = s4_data; end
            if (m_stall !== (c <= 16)) stall_ok = 1'b0;
            s = m_stall;
            @(posedge clk); #1;
            if (!hold || !s) start = 1'b0;
        end
        chk("m_pulses", 32'(vm), 32'd1);
        chk("m_done_cycle", 32'(cm), 32'd17);
        chk("m_data", dm, exp);
        chk("m_stall_pattern", {31'd0, stall_ok}, 32'd1);
        if (sweep) begin
            chk("bpc1_pulses", 32'(v1), 32'd1);
            chk("bpc1_done_cycle", 32'(c1), 32'd33);
            chk("bpc1_data", d1, exp);
            chk("bpc4_pulses", 32'(v4), 32'd1);
            chk("bpc4_done_cycle", 32'(c4), 32'd9);
            chk("bpc4_data", d4, exp);
        end
        exp_main = exp;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #7;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        vec_t tbl[5];
        int   vc;
        int   pc[2];
        logic [31:0] pd[2];
        bit   st_ok;

        tbl[0] = '{32'd3,        32'd4,        32'h0000000C};
        tbl[1] = '{32'hFFFFFFF9, 32'd6,        32'hFFFFFFD6};
        tbl[2] = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000};
        tbl[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
        tbl[4] = '{32'h00000000, 32'h12345678, 32'h00000000};

        rst_n = 1'b0; start = 1'b0; flush = 1'b0; data1 = '0; data2 = '0;
        #12;
        chk("rst_data", m_data, 32'h0);
        chk("rst_valid", {31'd0, m_valid}, 32'h0);
        chk("rst_busy", {31'd0, m_busy}, 32'h0);
        chk("rst_stall", {31'd0, m_stall}, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed table: start held until stall drops.
        for (int i = 0; i < 5; i++) begin
            run_op(tbl[i].a, tbl[i].b, 1'b1, 1'b0);
            chk("tbl_model_agrees", exp_main, tbl[i].exp);
        end

        // Back-to-back: 2x3 then 4x5 with start continuously high.
        vc = 0; st_ok = 1'b1; pc[0] = -1; pc[1] = -1; pd[0] = '0; pd[1] = '0;
        data1 = 32'd2; data2 = 32'd3; start = 1'b1;
        for (int c = 0; c < 36; c++) begin
            @(negedge clk);
            if (m_valid) begin
                if (vc < 2) begin pc[vc] = c; pd[vc] = m_data; end
                vc++;
            end
            if (m_stall !== !(c == 17 || c == 35)) st_ok = 1'b0;
            @(posedge clk); #1;
            if (c + 1 == 18) begin data1 = 32'd4; data2 = 32'd5; end
        end
        start = 1'b0;
        chk("b2b_pulses", 32'(vc), 32'd2);
        chk("b2b_cycle0", 32'(pc[0]), 32'd17);
        chk("b2b_data0", pd[0], 32'd6);
        chk("b2b_cycle1", 32'(pc[1]), 32'd35);
        chk("b2b_data1", pd[1], 32'd20);
        chk("b2b_stall_pattern", {31'd0, st_ok}, 32'd1);
        exp_main = 32'd20;
        @(posedge clk); #1;
        do_reset();
        exp_main = 32'd0;
        run_op(32'd4, 32'd5, 1'b0, 1'b1);

        // Flush at cycle 6 of a 5x5.
        vc = 0;
        data1 = 32'd5; data2 = 32'd5; start = 1'b1;
        for (int c = 0; c < 36; c++) begin
            @(negedge clk);
            if (m_valid) vc++;
            if (c == 6) chk("flush_busy_c6", {31'd0, m_busy}, 32'd1);
            if (c == 7) begin
                chk("flush_busy_c7", {31'd0, m_busy}, 32'd0);
                chk("flush_stall_c7", {31'd0, m_stall}, 32'd0);
            end
            @(posedge clk); #1;
            start = 1'b0;
            flush = (c + 1 == 6);
        end
        chk("flush_no_valid", 32'(vc), 32'd0);
        chk("flush_data_held", m_data, exp_main);

        // Asynchronous reset mid-cycle 8 of a 9x9.
        data1 = 32'd9; data2 = 32'd9; start = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        chk("amid_data", m_data, 32'h0);
        chk("amid_valid", {31'd0, m_valid}, 32'h0);
        chk("amid_busy", {31'd0, m_busy}, 32'h0);
        chk("amid_stall", {31'd0, m_stall}, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(32'd2, 32'd3, 1'b1, 1'b0);
        chk("after_rst_data", m_data, 32'd6);

        // Random sweep across all three BITS_PER_CYCLE settings.
        for (int i = 0; i < 1000; i++) begin
            run_op($urandom, $urandom, 1'b0, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ex_mul_unit.md
# ex_mul_unit

Iterative multi-cycle multiplier for the EX stage of the pipelined CPU. It replaces the single-cycle combinational MUL path of the EX-stage ALU. It takes the same forwarded operand pair the ALU receives and holds the pipeline through a stall output while it works. It then delivers the low 32 bits of the product to the EX/MEM register in the cycle the stall releases.

## Interface
Parameters:
- WIDTH, 32, operand and result width.
- BITS_PER_CYCLE, 2, multiplier bits retired per iteration.
  - Legal values are 1, 2 and 4, and the value must divide WIDTH.
  - N = WIDTH/BITS_PER_CYCLE is the number of iteration cycles.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset; asynchronous, active-low.
- start_i  input  1  the instruction in EX is a MUL (ALU control decodes to MUL).
- flush_i  input  1  the EX-stage instruction is squashed; abort any operation.
- data1_i  input  WIDTH  multiplicand (forwarded rs1 value).
- data2_i  input  WIDTH  multiplier (forwarded rs2 value).
- stall_o  output  1  freeze PC, IF/ID and ID/EX; hold EX/MEM input invalid.
- busy_o  output  1  the unit is in the BUSY state.
- valid_o  output  1  data_o carries a fresh product this cycle.
- data_o  output  WIDTH  product, low WIDTH bits.

## Operation
The unit is a three-state FSM: IDLE, BUSY, DONE.

IDLE:
- If start_i=1 and flush_i=0:
  - capture data1_i into mcand and data2_i into mplier;
  - clear acc;
  - clear the iteration counter cnt;
  - go to BUSY.
- Otherwise stay in IDLE.

BUSY, each cycle:
- acc += mcand * mplier[BITS_PER_CYCLE-1:0], truncated to WIDTH bits.
- mcand <<= BITS_PER_CYCLE.
- mplier >>= BITS_PER_CYCLE (logical shift).
- cnt += 1.
- When cnt = N-1 on this edge, load data_o with the final acc and go to DONE.

DONE:
- valid_o=1 for exactly one cycle.
- Always return to IDLE on the next edge.
- start_i is ignored in DONE, because it still reflects the same instruction that is leaving EX.

Arithmetic:
- The result is (data1_i * data2_i) mod 2^WIDTH.
- This result is identical for signed and unsigned interpretation, so no sign handling is required.
- All intermediate sums wrap at WIDTH bits.

Fixed latency:
- There is no early termination. Every operation takes N BUSY cycles regardless of operand values.

flush_i:
- Has priority over start_i.
- In BUSY or DONE, it forces IDLE on the next edge.
- valid_o is never asserted for an aborted operation, and data_o is not updated.

Output values by state:
- data_o holds its last value until the next completion.
- busy_o = (state==BUSY).

## Timing
stall_o is combinational: (state==IDLE && start_i && !flush_i) || state==BUSY.
- Cycle 0: IDLE with start_i=1; stall_o=1.
- Cycles 1..N: BUSY; stall_o=1.
- Cycle N+1: DONE; stall_o=0, valid_o=1, data_o valid. The pipeline advances at the end of this cycle.
- Total stall is N+1 cycles. For WIDTH=32 and BITS_PER_CYCLE=2, N=16 and DONE occurs at cycle 17.

Back-to-back MULs:
- A second MUL enters EX in cycle N+2.
- The unit sees it in IDLE, so the next result arrives in DONE at cycle 2N+3.

Reset (rst_i low, at any time including mid-operation):
- Immediately:
  - state=IDLE;
  - acc, mcand, mplier, cnt = 0;
  - data_o=0;
  - valid_o=0;
  - busy_o=0.
- stall_o=0 unless start_i=1 after reset deasserts.
- No valid_o pulse is produced for the interrupted operation.

Outputs valid_o, busy_o and data_o are registered. stall_o is the only combinational output.

## Test plan
- Basic: data1_i=3, data2_i=4, start_i held until stall_o falls. Required: stall_o=1 for cycles 0..16; valid_o=1 only at cycle 17; data_o=0x0000000C.
- Signed and wrap:
  - -7 × 6: data_o=0xFFFFFFD6.
  - 0x80000000 × 0xFFFFFFFF: data_o=0x80000000.
  - 0xFFFFFFFF × 0xFFFFFFFF: data_o=0x00000001.
  - 0 × 0x12345678: data_o=0x00000000, still after 16 BUSY cycles.
- Flush: start 5×5, assert flush_i at cycle 6. Required: busy_o=0 at cycle 7; stall_o=0 from cycle 7 with start_i=0; no valid_o pulse; data_o keeps its previous value.
- Reset mid-op: start 9×9, drop rst_i asynchronously mid-cycle 8. Required: all outputs 0 before the next edge. After release with start_i=1 on 2×3, the unit runs from scratch and data_o=6 at the new cycle 17.
- Back-to-back: 2×3 then 4×5. Required: valid_o pulses at cycles 17 and 35 with data_o=6 and 20; stall_o=0 only at cycles 17 and 35; no extra valid_o pulse from start_i seen in DONE.
- Parameter sweep: BITS_PER_CYCLE=1 and 4, with 1000 random operand pairs each. Required: DONE at cycles 33 and 9 respectively; data_o matches the truncated product.
